mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-master (fetch/data) arbiter for a single fixed-latency memory port.
// One transaction outstanding; data has priority with a starvation guard for fetch.
module mem_port_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [63:0] if_addr_i,
  input  logic        flush_i,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [63:0] dm_addr_i,
  input  logic [63:0] dm_wdata_i,
  input  logic [7:0]  dm_be_i,
  output logic        if_gnt_o,
  output logic        dm_gnt_o,
  output logic        if_rvalid_o,
  output logic        dm_rvalid_o,
  output logic [63:0] if_rdata_o,
  output logic [63:0] dm_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [63:0] mem_addr_o,
  output logic [63:0] mem_wdata_o,
  output logic [7:0]  mem_be_o,
  input  logic [63:0] mem_rdata_i,
  output logic        busy_o
);

  // state  | meaning
  // S_IDLE | no transaction outstanding, arbitration and grant happen here
  // S_WAIT | command issued, counting down memory latency
  // S_RESP | mem_rdata_i valid this cycle, owner's response strobe
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state, state_n;
  logic [3:0] lat_cnt, lat_cnt_n;
  logic [3:0] starve_cnt, starve_cnt_n;
  logic       owner_dm, owner_dm_n;
  logic       owner_we, owner_we_n;
  logic       drop, drop_n;
  logic       fetch_wins;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      owner_dm   <= 1'b0;
      owner_we   <= 1'b0;
      drop       <= 1'b0;
    end else begin
      state      <= state_n;
      lat_cnt    <= lat_cnt_n;
      starve_cnt <= starve_cnt_n;
      owner_dm   <= owner_dm_n;
      owner_we   <= owner_we_n;
      drop       <= drop_n;
    end
  end

  always_comb begin
    state_n      = state;
    lat_cnt_n    = lat_cnt;
    starve_cnt_n = starve_cnt;
    owner_dm_n   = owner_dm;
    owner_we_n   = owner_we;
    drop_n       = drop;
    if_gnt_o     = 1'b0;
    dm_gnt_o     = 1'b0;
    if_rvalid_o  = 1'b0;
    dm_rvalid_o  = 1'b0;
    if_rdata_o   = '0;
    dm_rdata_o   = '0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    mem_be_o     = '0;
    busy_o       = (state != S_IDLE);
    fetch_wins   = if_req_i && (!dm_req_i || starve_cnt == STARVE_LIM);

    case (state)
      S_IDLE: begin
        if (if_req_i || dm_req_i) begin
          mem_req_o = 1'b1;
          lat_cnt_n = LAT_INIT;
          state_n   = (MEM_LAT > 1) ? S_WAIT : S_RESP;
          if (fetch_wins) begin
            if_gnt_o     = 1'b1;
            mem_addr_o   = if_addr_i;
            owner_dm_n   = 1'b0;
            owner_we_n   = 1'b0;
            drop_n       = flush_i;
            starve_cnt_n = '0;
          end else begin
            dm_gnt_o    = 1'b1;
            mem_we_o    = dm_we_i;
            mem_addr_o  = dm_addr_i;
            mem_wdata_o = dm_wdata_i;
            mem_be_o    = dm_be_i;
            owner_dm_n  = 1'b1;
            owner_we_n  = dm_we_i;
            drop_n      = 1'b0;
            if (if_req_i && starve_cnt != STARVE_LIM)
              starve_cnt_n = starve_cnt + 4'd1;
          end
        end
      end
      S_WAIT: begin
        lat_cnt_n = lat_cnt - 4'd1;
        if (lat_cnt == 4'd1) state_n = S_RESP;
        if (!owner_dm && flush_i) drop_n = 1'b1;
      end
      S_RESP: begin
        state_n   = S_IDLE;
        lat_cnt_n = '0;
        drop_n    = 1'b0;
        if (owner_dm) begin
          dm_rvalid_o = 1'b1;
          dm_rdata_o  = owner_we ? 64'd0 : mem_rdata_i;
        end else if (!drop && !flush_i) begin
          if_rvalid_o = 1'b1;
          if_rdata_o  = mem_rdata_i;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Reset forces every output quiet, including the combinational grant path.
    if (rst_i) begin
      if_gnt_o    = 1'b0;
      dm_gnt_o    = 1'b0;
      if_rvalid_o = 1'b0;
      dm_rvalid_o = 1'b0;
      if_rdata_o  = '0;
      dm_rdata_o  = '0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_be_o    = '0;
      busy_o      = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LAT=2 main instance plus a MEM_LAT=1 instance
// for back-to-back throughput. Inputs change 1 unit after a rising edge; outputs checked 1 unit later.
module tb_mem_port_arbiter;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i, flush_i, dm_req_i, dm_we_i, if_req1;
  logic [63:0] if_addr_i, dm_addr_i, dm_wdata_i, mem_rdata_i;
  logic [7:0]  dm_be_i;
  logic        if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o, mem_req_o, mem_we_o, busy_o;
  logic [63:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
  logic [7:0]  mem_be_o;
  logic        if_gnt1, dm_gnt1, if_rvalid1, dm_rvalid1, mem_req1, mem_we1, busy1;
  logic [63:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1;
  logic [7:0]  mem_be1;
  int pass_cnt = 0;
  int total    = 0;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(.MEM_LAT(2), .STARVE_MAX(3)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .if_req_i(if_req_i), .if_addr_i(if_addr_i), .flush_i(flush_i),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_be_i(dm_be_i), .if_gnt_o(if_gnt_o), .dm_gnt_o(dm_gnt_o), .if_rvalid_o(if_rvalid_o),
    .dm_rvalid_o(dm_rvalid_o), .if_rdata_o(if_rdata_o), .dm_rdata_o(dm_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o));

  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(3)) u_dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .if_req_i(if_req1), .if_addr_i(if_addr_i), .flush_i(1'b0),
    .dm_req_i(1'b0), .dm_we_i(1'b0), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_be_i(dm_be_i), .if_gnt_o(if_gnt1), .dm_gnt_o(dm_gnt1), .if_rvalid_o(if_rvalid1),
    .dm_rvalid_o(dm_rvalid1), .if_rdata_o(if_rdata1), .dm_rdata_o(dm_rdata1),
    .mem_req_o(mem_req1), .mem_we_o(mem_we1), .mem_addr_o(mem_addr1),
    .mem_wdata_o(mem_wdata1), .mem_be_o(mem_be1), .mem_rdata_i(mem_rdata_i), .busy_o(busy1));

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; if_req_i = 1'b1; dm_req_i = 1'b1; if_req1 = 1'b0; flush_i = 1'b0;
    dm_we_i = 1'b0; if_addr_i = 64'h10; dm_addr_i = 64'h20; dm_wdata_i = 64'h30; dm_be_i = 8'hFF;
    mem_rdata_i = 64'h0;
    tick(); tick(); settle();
    total++; if ({if_gnt_o, dm_gnt_o, mem_req_o, busy_o} !== 4'b0)
      $display("FAIL reset_strobes: got %b want 0000", {if_gnt_o, dm_gnt_o, mem_req_o, busy_o}); else pass_cnt++;
    total++; if (mem_addr_o !== 64'h0 || mem_be_o !== 8'h0)
      $display("FAIL reset_fields: got addr %h be %h want 0", mem_addr_o, mem_be_o); else pass_cnt++;
    tick(); rst_i = 1'b0; if_req_i = 1'b0; dm_req_i = 1'b0; settle();
    total++; if ({if_gnt_o, dm_gnt_o, mem_req_o, if_rvalid_o, dm_rvalid_o, busy_o} !== 6'b0)
      $display("FAIL idle_quiet: got %b want 000000",
               {if_gnt_o, dm_gnt_o, mem_req_o, if_rvalid_o, dm_rvalid_o, busy_o}); else pass_cnt++;
  endtask

  task automatic test_single_fetch();
    tick(); if_req_i = 1'b1; if_addr_i = 64'h1000; mem_rdata_i = 64'hA5A5_0000_1234_5678; settle();
    total++; if ({if_gnt_o, mem_req_o, mem_we_o, busy_o} !== 4'b1100)
      $display("FAIL fetch_grant: got %b want 1100", {if_gnt_o, mem_req_o, mem_we_o, busy_o}); else pass_cnt++;
    total++; if (mem_addr_o !== 64'h1000)
      $display("FAIL fetch_addr: got %h want 1000", mem_addr_o); else pass_cnt++;
    tick(); if_req_i = 1'b0; settle();
    total++; if ({busy_o, if_rvalid_o, mem_req_o} !== 3'b100)
      $display("FAIL fetch_wait: got %b want 100", {busy_o, if_rvalid_o, mem_req_o}); else pass_cnt++;
    tick(); settle();
    total++; if ({busy_o, if_rvalid_o} !== 2'b11 || if_rdata_o !== 64'hA5A5_0000_1234_5678)
      $display("FAIL fetch_resp: got %b %h want 11 a5a5000012345678", {busy_o, if_rvalid_o}, if_rdata_o); else pass_cnt++;
    tick(); settle();
    total++; if ({busy_o, if_rvalid_o} !== 2'b00 || if_rdata_o !== 64'h0)
      $display("FAIL fetch_done: got %b %h want 00 0", {busy_o, if_rvalid_o}, if_rdata_o); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    if_req_i = 1'b1; dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 64'h2000; if_addr_i = 64'h3000;
    mem_rdata_i = 64'h0000_0000_DEAD_BEEF; settle();
    total++; if ({dm_gnt_o, if_gnt_o} !== 2'b10 || mem_addr_o !== 64'h2000)
      $display("FAIL simul_data_first: got %b %h want 10 2000", {dm_gnt_o, if_gnt_o}, mem_addr_o); else pass_cnt++;
    tick(); dm_req_i = 1'b0; tick(); settle();
    total++; if (dm_rvalid_o !== 1'b1 || dm_rdata_o !== 64'hDEAD_BEEF || if_rvalid_o !== 1'b0)
      $display("FAIL simul_data_resp: got %b %h want 1 deadbeef", dm_rvalid_o, dm_rdata_o); else pass_cnt++;
    tick(); settle();
    total++; if ({dm_gnt_o, if_gnt_o} !== 2'b01 || mem_addr_o !== 64'h3000)
      $display("FAIL simul_fetch_next: got %b %h want 01 3000", {dm_gnt_o, if_gnt_o}, mem_addr_o); else pass_cnt++;
    tick(); if_req_i = 1'b0; tick(); tick();
  endtask

  task automatic test_starvation();
    logic [6:0] exp_fetch;
    exp_fetch = 7'b0001000;
    if_req_i = 1'b1; dm_req_i = 1'b1; dm_we_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      settle();
      total++; if ({if_gnt_o, dm_gnt_o} !== {exp_fetch[6-i], ~exp_fetch[6-i]})
        $display("FAIL starve_grant_%0d: got if/dm %b want %b", i, {if_gnt_o, dm_gnt_o},
                 {exp_fetch[6-i], ~exp_fetch[6-i]}); else pass_cnt++;
      tick(); tick();
      if (i == 6) begin if_req_i = 1'b0; dm_req_i = 1'b0; end
      tick();
    end
  endtask

  task automatic test_write();
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_be_i = 8'h0F; dm_addr_i = 64'h4000;
    dm_wdata_i = 64'h1122_3344_5566_7788; mem_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF; settle();
    total++; if ({dm_gnt_o, mem_req_o, mem_we_o} !== 3'b111 || mem_be_o !== 8'h0F)
      $display("FAIL write_cmd: got %b be %h want 111 0f", {dm_gnt_o, mem_req_o, mem_we_o}, mem_be_o); else pass_cnt++;
    total++; if (mem_wdata_o !== 64'h1122_3344_5566_7788)
      $display("FAIL write_data: got %h want 1122334455667788", mem_wdata_o); else pass_cnt++;
    tick(); dm_req_i = 1'b0; dm_we_i = 1'b0; tick(); settle();
    total++; if (dm_rvalid_o !== 1'b1 || dm_rdata_o !== 64'h0)
      $display("FAIL write_resp: got %b %h want 1 0", dm_rvalid_o, dm_rdata_o); else pass_cnt++;
    tick();
  endtask

  task automatic test_flush();
    if_req_i = 1'b1; if_addr_i = 64'h5000; mem_rdata_i = 64'h77; settle();
    total++; if (if_gnt_o !== 1'b1)
      $display("FAIL flush_grant: got %b want 1", if_gnt_o); else pass_cnt++;
    tick(); if_req_i = 1'b0; flush_i = 1'b1;
    tick(); flush_i = 1'b0; settle();
    total++; if ({busy_o, if_rvalid_o} !== 2'b10 || if_rdata_o !== 64'h0)
      $display("FAIL flush_drop: got %b %h want 10 0", {busy_o, if_rvalid_o}, if_rdata_o); else pass_cnt++;
    tick(); if_req_i = 1'b1; if_addr_i = 64'h5008; settle();
    total++; if (if_gnt_o !== 1'b1 || mem_addr_o !== 64'h5008)
      $display("FAIL flush_next_grant: got %b %h want 1 5008", if_gnt_o, mem_addr_o); else pass_cnt++;
    tick(); if_req_i = 1'b0; tick(); settle();
    total++; if (if_rvalid_o !== 1'b1 || if_rdata_o !== 64'h77)
      $display("FAIL flush_cleared: got %b %h want 1 77", if_rvalid_o, if_rdata_o); else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid();
    if_req_i = 1'b1; if_addr_i = 64'h6000; mem_rdata_i = 64'h99; settle();
    total++; if (if_gnt_o !== 1'b1)
      $display("FAIL rstmid_grant: got %b want 1", if_gnt_o); else pass_cnt++;
    tick(); if_req_i = 1'b0; rst_i = 1'b1; settle();
    total++; if ({busy_o, if_rvalid_o, mem_req_o, if_gnt_o, dm_gnt_o} !== 5'b0)
      $display("FAIL rstmid_outputs: got %b want 00000",
               {busy_o, if_rvalid_o, mem_req_o, if_gnt_o, dm_gnt_o}); else pass_cnt++;
    tick(); rst_i = 1'b0; settle();
    total++; if ({busy_o, if_rvalid_o} !== 2'b00)
      $display("FAIL rstmid_abandon: got %b want 00", {busy_o, if_rvalid_o}); else pass_cnt++;
    tick(); settle();
    total++; if ({busy_o, if_rvalid_o} !== 2'b00)
      $display("FAIL rstmid_late_data: got %b want 00", {busy_o, if_rvalid_o}); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    if_req1 = 1'b1; mem_rdata_i = 64'hC0DE;
    for (int i = 0; i < 6; i++) begin
      settle();
      if (i % 2 == 0) begin
        total++; if ({if_gnt1, if_rvalid1} !== 2'b10)
          $display("FAIL b2b_grant_%0d: got gnt/rvalid %b want 10", i, {if_gnt1, if_rvalid1}); else pass_cnt++;
      end else begin
        total++; if ({if_gnt1, if_rvalid1} !== 2'b01 || if_rdata1 !== 64'hC0DE)
          $display("FAIL b2b_resp_%0d: got %b %h want 01 c0de", i, {if_gnt1, if_rvalid1}, if_rdata1); else pass_cnt++;
      end
      tick();
    end
    if_req1 = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_write();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
